ram_arbiter: RTL

- Shares the single-port data block RAM (synchronous, 1-cycle read latency) between two requesters.
- Port 0 is the core load/store path. Port 1 is the loader/debug DMA that fills and inspects data memory.
- Round-robin arbitration with a bounded burst hold, so a streaming requester cannot starve the other.
- Sits between the requesters and block_ram; routes each read response back to its issuer one cycle after the grant.

---
 rtl/mem_pkg.sv | 15 +
 rtl/rr_pick.sv | 43 ++++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

    localparam int DATA_W     = 32;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin picker with bounded burst hold; one-hot grant out.
// Latency: purely combinational.
// Backpressure: a non-granted requester simply waits; the holder yields after BURST_MAX grants.
module rr_pick
    import mem_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic [1:0] req,
    input  owner_t     state,
    input  logic [7:0] burst_cnt,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    logic hold0;
    logic hold1;

    // The owner keeps the RAM while the other port is quiet or its burst budget remains.
    assign hold0 = req[0] && (!req[1] || (burst_cnt < BURST_LIM));
    assign hold1 = req[1] && (!req[0] || (burst_cnt < BURST_LIM));

    always_comb begin
        gnt = 2'b00;
        case (state)
            OWN0: begin
                if (hold0)       gnt = 2'b01;
                else if (req[1]) gnt = 2'b10;
            end
            OWN1: begin
                if (hold1)       gnt = 2'b10;
                else if (req[0]) gnt = 2'b01;
            end
            default: begin
                if (req == 2'b11) gnt = last_owner ? 2'b01 : 2'b10;
                else              gnt = req;
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the core (port 0) and loader/debug DMA (port 1).
// Latency: grant is same-cycle; read data returns with rvalid one cycle after the grant.
// Backpressure: requesters hold req stable until gnt; bounded burst hold prevents starvation.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              rvalid0,

    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              rvalid1,

    output logic [31:0]       rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_dout
);

    owner_t      state;
    owner_t      state_nx;
    logic        last_owner;
    logic        last_owner_nx;
    logic [7:0]  burst_cnt;
    logic [7:0]  burst_nx;
    logic [7:0]  burst_inc;
    logic [1:0]  pick_gnt;
    logic [1:0]  gnt;

    rr_pick #(
        .BURST_MAX (BURST_MAX)
    ) u_pick (
        .req        ({req1, req0}),
        .state      (state),
        .burst_cnt  (burst_cnt),
        .last_owner (last_owner),
        .gnt        (pick_gnt)
    );

    assign gnt  = rst ? 2'b00 : pick_gnt;
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    assign burst_inc = (burst_cnt == 8'hFF) ? 8'hFF : burst_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= 8'd0;
        end else begin
            state      <= state_nx;
            last_owner <= last_owner_nx;
            burst_cnt  <= burst_nx;
        end
    end

    always_comb begin
        state_nx      = IDLE;
        last_owner_nx = last_owner;
        burst_nx      = 8'd0;
        if (gnt[0]) begin
            state_nx      = OWN0;
            last_owner_nx = 1'b0;
            burst_nx      = (state == OWN0) ? burst_inc : 8'd1;
        end else if (gnt[1]) begin
            state_nx      = OWN1;
            last_owner_nx = 1'b1;
            burst_nx      = (state == OWN1) ? burst_inc : 8'd1;
        end
    end

    // Byte address to word address; sub-word and out-of-range bits are dropped silently.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (gnt[0]) begin
            ram_we   = we0;
            ram_addr = addr0[WORD_SHIFT +: ADDR_W];
            ram_di   = wdata0;
        end else if (gnt[1]) begin
            ram_we   = we1;
            ram_addr = addr1[WORD_SHIFT +: ADDR_W];
            ram_di   = wdata1;
        end
    end

    assign ram_en = gnt[0] | gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt[0] & ~we0;
            rvalid1 <= gnt[1] & ~we1;
        end
    end

    assign rdata = ram_dout;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:ADDR_W+WORD_SHIFT], addr0[WORD_SHIFT-1:0],
                                addr1[31:ADDR_W+WORD_SHIFT], addr1[WORD_SHIFT-1:0]};

endmodule
